// File: rtl/core_if_pcgen_ras_pkg.sv
// Shared constants and next-PC source encoding for the IF-stage PC generator.
package core_if_pcgen_ras_pkg;

    localparam int unsigned CORE_PC_WIDTH = 32;
    localparam logic [CORE_PC_WIDTH-1:0] CORE_PC_RESET_VALUE = 32'h8000_0000;
    localparam int unsigned CORE_FETCH_BYTES = 4;
    localparam int unsigned CORE_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        NPC_FLUSH = 2'd0,
        NPC_RAS   = 2'd1,
        NPC_BJ    = 2'd2,
        NPC_SEQ   = 2'd3
    } npc_src_e;

endpackage

// File: rtl/core_if_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module core_if_ras
    import core_if_pcgen_ras_pkg::*;
#(
    parameter int unsigned WIDTH = CORE_PC_WIDTH,
    parameter int unsigned DEPTH = CORE_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_swap;
    logic             do_pop;

    assign empty    = (count == CNT_W'(0));
    assign full     = (count == CNT_W'(DEPTH));
    assign top_data = mem[top_ptr];

    // Push+pop on a non-empty stack replaces the top; on an empty stack it is a plain push.
    always_comb begin
        do_push = 1'b0;
        do_swap = 1'b0;
        do_pop  = 1'b0;
        if (push && pop && !empty) begin
            do_swap = 1'b1;
        end else if (push) begin
            do_push = 1'b1;
        end else if (pop && !empty) begin
            do_pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (do_push) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr) begin
            if (do_push) begin
                mem[top_ptr + PTR_W'(1)] <= push_data;
            end else if (do_swap) begin
                mem[top_ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/core_if_pcgen_ras.sv
// IF-stage PC generator: fetch PC register, next-PC select (flush/RAS/BJU/sequential) and RAS.
module core_if_pcgen_ras
    import core_if_pcgen_ras_pkg::*;
#(
    parameter int unsigned             PC_WIDTH         = CORE_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]     RESET_PC         = CORE_PC_RESET_VALUE,
    parameter int unsigned             FETCH_BYTES      = CORE_FETCH_BYTES,
    parameter int unsigned             RAS_DEPTH        = CORE_RAS_DEPTH,
    parameter bit                      RAS_CLR_ON_FLUSH = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_update_en,
    input  logic                pipe_flush_req,
    input  logic [PC_WIDTH-1:0] exu_pipe_flush_pc,
    input  logic                bju_pc_bj_predict,
    input  logic [PC_WIDTH-1:0] bju_pc_offset,
    input  logic                ras_push,
    input  logic                ras_pop,
    output logic [PC_WIDTH-1:0] pc_current,
    output logic                pc_valid,
    output logic                branch_jump_predict,
    output logic                ras_hit,
    output logic                ras_empty,
    output logic                ras_full
);

    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] ras_top;
    logic [PC_WIDTH-1:0] pc_next;
    npc_src_e            npc_src;
    logic                advance;

    assign pc_seq  = pc_current + PC_WIDTH'(FETCH_BYTES);
    assign ras_hit = ras_pop && !ras_empty;
    assign advance = pc_update_en && !pipe_flush_req && pc_valid;

    assign branch_jump_predict = !pipe_flush_req && (ras_hit || bju_pc_bj_predict);

    // Next-PC source priority and target mux.
    always_comb begin
        npc_src = NPC_SEQ;
        pc_next = pc_seq;
        if (pipe_flush_req) begin
            npc_src = NPC_FLUSH;
        end else if (ras_hit) begin
            npc_src = NPC_RAS;
        end else if (bju_pc_bj_predict) begin
            npc_src = NPC_BJ;
        end
        case (npc_src)
            NPC_FLUSH: pc_next = exu_pipe_flush_pc;
            NPC_RAS:   pc_next = ras_top;
            NPC_BJ:    pc_next = pc_current + bju_pc_offset;
            default:   pc_next = pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_current <= RESET_PC;
            pc_valid   <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (pipe_flush_req || pc_update_en) begin
                pc_current <= pc_next;
            end
        end
    end

    core_if_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (advance && ras_push),
        .pop       (advance && ras_pop),
        .clr       (pipe_flush_req && RAS_CLR_ON_FLUSH),
        .push_data (pc_seq),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_core_if_pcgen_ras.sv
// Bench for core_if_pcgen_ras: directed scenarios plus random traffic against a queue-based model.
module tb_core_if_pcgen_ras;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        pc_update_en;
    logic        pipe_flush_req;
    logic [31:0] exu_pipe_flush_pc;
    logic        bju_pc_bj_predict;
    logic [31:0] bju_pc_offset;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc_current;
    logic        pc_valid;
    logic        branch_jump_predict;
    logic        ras_hit;
    logic        ras_empty;
    logic        ras_full;

    int checks;
    int errors;

    // Reference model: PC, valid flag and the stack as a queue (back = top, front = oldest).
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_q[$];

    core_if_pcgen_ras dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_update_en        (pc_update_en),
        .pipe_flush_req      (pipe_flush_req),
        .exu_pipe_flush_pc   (exu_pipe_flush_pc),
        .bju_pc_bj_predict   (bju_pc_bj_predict),
        .bju_pc_offset       (bju_pc_offset),
        .ras_push            (ras_push),
        .ras_pop             (ras_pop),
        .pc_current          (pc_current),
        .pc_valid            (pc_valid),
        .branch_jump_predict (branch_jump_predict),
        .ras_hit             (ras_hit),
        .ras_empty           (ras_empty),
        .ras_full            (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step();
        logic        hit;
        logic        adv;
        logic [31:0] seq;
        logic [31:0] nxt;
        hit = ras_pop && (m_q.size() != 0);
        seq = m_pc + 32'd4;
        if (pipe_flush_req)         nxt = exu_pipe_flush_pc;
        else if (hit)               nxt = m_q[m_q.size()-1];
        else if (bju_pc_bj_predict) nxt = m_pc + bju_pc_offset;
        else                        nxt = seq;
        if (rst) begin
            m_pc    = RST_PC;
            m_valid = 1'b0;
            m_q.delete();
        end else begin
            adv = pc_update_en && !pipe_flush_req && m_valid;
            if (pipe_flush_req) begin
                m_q.delete();
            end else if (adv) begin
                if (ras_push && ras_pop && m_q.size() != 0) begin
                    m_q[m_q.size()-1] = seq;
                end else if (ras_push) begin
                    if (m_q.size() == 4) void'(m_q.pop_front());
                    m_q.push_back(seq);
                end else if (ras_pop && m_q.size() != 0) begin
                    void'(m_q.pop_back());
                end
            end
            if (pipe_flush_req || pc_update_en) m_pc = nxt;
            m_valid = 1'b1;
        end
    endfunction

    task automatic drive(input logic r, input logic upd, input logic fl, input logic [31:0] fpc,
                         input logic bj, input logic [31:0] off, input logic pu, input logic po);
        rst               = r;
        pc_update_en      = upd;
        pipe_flush_req    = fl;
        exu_pipe_flush_pc = fpc;
        bju_pc_bj_predict = bj;
        bju_pc_offset     = off;
        ras_push          = pu;
        ras_pop           = po;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
        checks++; if (pc_current !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_current, RST_PC); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras empty=%b full=%b exp=1/0", ras_empty, ras_full); end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (pc_current !== 32'h8000_0004 || pc_valid !== 1'b1) begin errors++; $display("FAIL seq1 pc=%h v=%b exp=80000004/1", pc_current, pc_valid); end
        tick();
        checks++; if (pc_current !== 32'h8000_0008) begin errors++; $display("FAIL seq2 pc=%h exp=80000008", pc_current); end
    endtask

    task automatic test_hold_flush();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++; if (pc_current !== 32'h8000_0008) begin errors++; $display("FAIL hold pc=%h exp=80000008", pc_current); end
        drive(0, 0, 1, 32'h8000_1000, 0, 0, 0, 0);
        tick();
        checks++; if (pc_current !== 32'h8000_1000) begin errors++; $display("FAIL flush_noupd pc=%h exp=80001000", pc_current); end
    endtask

    task automatic test_bju();
        drive(0, 0, 1, 32'h8000_0010, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 1, 32'hFFFF_FFF0, 0, 0);
        checks++; if (branch_jump_predict !== 1'b1) begin errors++; $display("FAIL bju_pred got=%b exp=1", branch_jump_predict); end
        tick();
        checks++; if (pc_current !== 32'h8000_0000) begin errors++; $display("FAIL bju_target pc=%h exp=80000000", pc_current); end
        drive(0, 0, 1, 32'h8000_0010, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 32'h8000_2000, 1, 32'hFFFF_FFF0, 0, 0);
        checks++; if (branch_jump_predict !== 1'b0) begin errors++; $display("FAIL flush_vs_bju pred got=%b exp=0", branch_jump_predict); end
        tick();
        checks++; if (pc_current !== 32'h8000_2000) begin errors++; $display("FAIL flush_vs_bju pc=%h exp=80002000", pc_current); end
    endtask

    task automatic test_ras_basic();
        drive(0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 0, 1, 32'h0000_00FC, 0, 0);
        tick();
        checks++; if (pc_current !== 32'h8000_0200) begin errors++; $display("FAIL ras_setup pc=%h exp=80000200", pc_current); end
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        checks++; if (ras_hit !== 1'b1 || branch_jump_predict !== 1'b1) begin errors++; $display("FAIL pop1_hit hit=%b pred=%b exp=1/1", ras_hit, branch_jump_predict); end
        tick();
        checks++; if (pc_current !== 32'h8000_0204) begin errors++; $display("FAIL pop1 pc=%h exp=80000204", pc_current); end
        tick();
        checks++; if (pc_current !== 32'h8000_0104) begin errors++; $display("FAIL pop2 pc=%h exp=80000104", pc_current); end
        checks++; if (ras_hit !== 1'b0 || ras_empty !== 1'b1) begin errors++; $display("FAIL pop3_empty hit=%b empty=%b exp=0/1", ras_hit, ras_empty); end
        tick();
        checks++; if (pc_current !== 32'h8000_0108) begin errors++; $display("FAIL pop3_seq pc=%h exp=80000108", pc_current); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_pc;
        drive(0, 0, 1, 32'h8000_3000, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++; if (ras_full !== 1'b1 || pc_current !== 32'h8000_3014) begin errors++; $display("FAIL ovf_full full=%b pc=%h exp=1/80003014", ras_full, pc_current); end
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h8000_3014 - 32'(4 * i);
            tick();
            checks++; if (pc_current !== exp_pc) begin errors++; $display("FAIL ovf_pop%0d pc=%h exp=%h", i, pc_current, exp_pc); end
        end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL ovf_drain empty=%b full=%b exp=1/0", ras_empty, ras_full); end
    endtask

    task automatic test_push_pop_flush();
        drive(0, 0, 1, 32'h8000_4000, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 1);
        tick();
        checks++; if (pc_current !== 32'h8000_4008 || ras_empty !== 1'b0) begin errors++; $display("FAIL swap pc=%h empty=%b exp=80004008/0", pc_current, ras_empty); end
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        tick();
        checks++; if (pc_current !== 32'h8000_400C) begin errors++; $display("FAIL swap_top pc=%h exp=8000400c", pc_current); end
        tick();
        checks++; if (pc_current !== 32'h8000_4004 || ras_empty !== 1'b1) begin errors++; $display("FAIL swap_count pc=%h empty=%b exp=80004004/1", pc_current, ras_empty); end
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 1, 32'h8000_5000, 0, 0, 1, 0);
        tick();
        checks++; if (ras_empty !== 1'b1 || pc_current !== 32'h8000_5000) begin errors++; $display("FAIL flush_clr empty=%b pc=%h exp=1/80005000", ras_empty, pc_current); end
    endtask

    task automatic test_mid_reset();
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        drive(1, 1, 1, 32'h8000_6000, 1, 32'h40, 1, 1);
        tick();
        checks++; if (pc_current !== RST_PC || pc_valid !== 1'b0 || ras_empty !== 1'b1) begin errors++; $display("FAIL midrst pc=%h v=%b empty=%b exp=80000000/0/1", pc_current, pc_valid, ras_empty); end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++; if (pc_current !== 32'h8000_0008 || pc_valid !== 1'b1) begin errors++; $display("FAIL midrst_seq pc=%h v=%b exp=80000008/1", pc_current, pc_valid); end
    endtask

    task automatic test_random();
        logic m_hit;
        logic m_pred;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
                  $urandom & 32'hFFFF_FFFC, ($urandom % 4) == 0, $urandom & 32'h0000_0FFC,
                  ($urandom % 3) == 0, ($urandom % 3) == 0);
            m_hit  = ras_pop && (m_q.size() != 0);
            m_pred = !pipe_flush_req && (m_hit || bju_pc_bj_predict);
            checks++; if (ras_hit !== m_hit || branch_jump_predict !== m_pred) begin errors++; $display("FAIL rnd%0d_comb hit=%b pred=%b exp=%b/%b", n, ras_hit, branch_jump_predict, m_hit, m_pred); end
            tick();
            checks++;
            if (pc_current !== m_pc || pc_valid !== m_valid || ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == 4)) begin
                errors++;
                $display("FAIL rnd%0d_state pc=%h v=%b e=%b f=%b exp=%h/%b/%b/%b", n, pc_current, pc_valid, ras_empty, ras_full,
                         m_pc, m_valid, m_q.size() == 0, m_q.size() == 4);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hold_flush();
        test_bju();
        test_ras_basic();
        test_ras_overflow();
        test_push_pop_flush();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
